// File: rtl/bridge_host_fsm.sv
// Host-side command initiator for the UART-to-SPI bridge: serializes opcode/argument bytes and collects the response.
// Optional response timeout is built only when BRIDGE_HOST_TIMEOUT_EN is defined.
module bridge_host_fsm #(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_code,
   input  logic [15:0] cmd_arg,
   output logic        cmd_done,
   output logic        rsp_valid,
   output logic [7:0]  rsp_data,
   output logic        rsp_timeout,
   output logic        busy,
   output logic        tx_req,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_ready,
   output logic [7:0]  cmd_count,
   output logic [2:0]  dbg_state
);

   // Handshakes: a command transfers on a cycle with cmd_valid && cmd_ready; a tx byte
   // transfers on a cycle with tx_req && tx_ready, and tx_req/tx_data stay put until then.
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_OP    = 3'd1;
   localparam logic [2:0] S_ARG_L = 3'd2;
   localparam logic [2:0] S_ARG_H = 3'd3;
   localparam logic [2:0] S_RSP   = 3'd4;

   logic [2:0]  r_state;
   logic [7:0]  r_code;
   logic [15:0] r_arg;
   logic        r_tx_req;
   logic [7:0]  r_tx_data;
   logic [7:0]  r_rsp_data;
   logic        r_cmd_done;
   logic        r_rsp_valid;
   logic        r_rsp_timeout;
   logic [7:0]  r_cmd_count;

   logic w_has_arg;
   logic w_is_baud;
   logic w_rsp_exp;
   logic w_to_hit;

   assign w_has_arg = (r_code >= 8'h01) && (r_code <= 8'h06);
   assign w_is_baud = (r_code == 8'h04);
   assign w_rsp_exp = (r_code == 8'h01) || (r_code == 8'h06);

`ifdef BRIDGE_HOST_TIMEOUT_EN
   logic [23:0] r_to_cnt;

   // Held at zero outside S_RSP, so every response wait starts from a cleared count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_to_cnt <= '0;
      end else if (r_state != S_RSP) begin
         r_to_cnt <= '0;
      end else if (!rx_ready) begin
         r_to_cnt <= r_to_cnt + 24'd1;
      end
   end

   assign w_to_hit = (r_to_cnt == (TIMEOUT_CYCLES - 24'd1));
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^TIMEOUT_CYCLES;
   assign w_to_hit         = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_code        <= '0;
         r_arg         <= '0;
         r_tx_req      <= 1'b0;
         r_tx_data     <= '0;
         r_rsp_data    <= '0;
         r_cmd_done    <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_timeout <= 1'b0;
         r_cmd_count   <= '0;
      end else begin
         r_cmd_done    <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_code      <= cmd_code;
                  r_arg       <= cmd_arg;
                  r_cmd_count <= r_cmd_count + 8'd1;
                  r_state     <= S_OP;
               end
            end
            S_OP: begin
               if (!r_tx_req) begin
                  r_tx_req  <= 1'b1;
                  r_tx_data <= r_code;
               end else if (tx_ready) begin
                  r_tx_req <= 1'b0;
                  if (w_has_arg) begin
                     r_state <= S_ARG_L;
                  end else begin
                     r_cmd_done <= 1'b1;
                     r_state    <= S_IDLE;
                  end
               end
            end
            S_ARG_L: begin
               if (!r_tx_req) begin
                  r_tx_req  <= 1'b1;
                  r_tx_data <= r_arg[7:0];
               end else if (tx_ready) begin
                  r_tx_req <= 1'b0;
                  if (w_is_baud) begin
                     r_state <= S_ARG_H;
                  end else if (w_rsp_exp && rx_ready) begin
                     // A reply landing with the last byte's accept is taken as the response.
                     r_rsp_data  <= rx_data;
                     r_rsp_valid <= 1'b1;
                     r_cmd_done  <= 1'b1;
                     r_state     <= S_IDLE;
                  end else if (w_rsp_exp) begin
                     r_state <= S_RSP;
                  end else begin
                     r_cmd_done <= 1'b1;
                     r_state    <= S_IDLE;
                  end
               end
            end
            S_ARG_H: begin
               if (!r_tx_req) begin
                  r_tx_req  <= 1'b1;
                  r_tx_data <= r_arg[15:8];
               end else if (tx_ready) begin
                  r_tx_req   <= 1'b0;
                  r_cmd_done <= 1'b1;
                  r_state    <= S_IDLE;
               end
            end
            S_RSP: begin
               if (rx_ready) begin
                  r_rsp_data  <= rx_data;
                  r_rsp_valid <= 1'b1;
                  r_cmd_done  <= 1'b1;
                  r_state     <= S_IDLE;
               end else if (w_to_hit) begin
                  r_rsp_timeout <= 1'b1;
                  r_cmd_done    <= 1'b1;
                  r_state       <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready   = (r_state == S_IDLE);
   assign busy        = ~cmd_ready;
   assign cmd_done    = r_cmd_done;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_data    = r_rsp_data;
   assign rsp_timeout = r_rsp_timeout;
   assign tx_req      = r_tx_req;
   assign tx_data     = r_tx_data;
   assign cmd_count   = r_cmd_count;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_bridge_host_fsm.sv
// Bench for bridge_host_fsm: directed protocol steps plus a randomized command stream checked against a byte-list model.
// Timeout expectations depend on whether BRIDGE_HOST_TIMEOUT_EN is defined.
module tb_bridge_host_fsm;

   localparam int TO = 16;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_code;
   logic [15:0] cmd_arg;
   logic        cmd_done;
   logic        rsp_valid;
   logic [7:0]  rsp_data;
   logic        rsp_timeout;
   logic        busy;
   logic        tx_req;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic [7:0]  cmd_count;
   logic [2:0]  dbg_state;

   int          errors = 0;
   int          checks = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  exp_count;
   logic [7:0]  exp_rsp_data;
   int          tx_hs_count = 0;
   bit          auto_en;

   bridge_host_fsm #(.TIMEOUT_CYCLES(TO[23:0])) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code), .cmd_arg(cmd_arg),
      .cmd_done(cmd_done), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
      .busy(busy), .tx_req(tx_req), .tx_data(tx_data), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_ready(rx_ready), .cmd_count(cmd_count), .dbg_state(dbg_state)
   );

   // clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: the byte stream a command must produce on the UART side.
   function automatic int model_push(input logic [7:0] code, input logic [15:0] arg);
      int n;
      if (code == 8'h04) n = 2;
      else if (code >= 8'h01 && code <= 8'h06) n = 1;
      else n = 0;
      exp_q.push_back(code);
      if (n >= 1) exp_q.push_back(arg[7:0]);
      if (n == 2) exp_q.push_back(arg[15:8]);
      return n + 1;
   endfunction

   // UART transmitter stand-in: accepts a pending byte after a random wait.
   initial begin
      tx_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (auto_en) begin
            if (tx_ready) tx_ready = 1'b0;
            else if (tx_req && $urandom_range(0, 2) == 0) tx_ready = 1'b1;
         end
      end
   end

   // Scoreboard and protocol monitor, sampled mid-cycle.
   logic       prev_req, prev_rdy, prev_hs, prev_rst;
   logic [7:0] prev_data;
   initial begin
      prev_req = 0; prev_rdy = 0; prev_hs = 0; prev_rst = 0; prev_data = 0;
   end

   always @(negedge clk) begin
      if (rst_n && prev_rst) begin
         if (tx_req && tx_ready) begin
            tx_hs_count++;
            if (exp_q.size() == 0) chk("tx_extra_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
            else chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
         end
         if (prev_hs) chk("tx_gap", {31'd0, tx_req}, 32'd0);
         if (prev_req && !prev_rdy) begin
            chk("tx_req_hold", {31'd0, tx_req}, 32'd1);
            chk("tx_data_stable", {24'd0, tx_data}, {24'd0, prev_data});
         end
         if (rsp_valid) chk("rsp_valid_with_done", {31'd0, cmd_done}, 32'd1);
         if (rsp_timeout) chk("timeout_with_done", {31'd0, cmd_done}, 32'd1);
      end
      prev_req  = tx_req;
      prev_rdy  = tx_ready;
      prev_hs   = tx_req && tx_ready;
      prev_data = tx_data;
      prev_rst  = rst_n;
   end

   task automatic accept_cmd(input logic [7:0] code, input logic [15:0] arg);
      bit acc;
      acc = 0;
      cmd_code  = code;
      cmd_arg   = arg;
      cmd_valid = 1'b1;
      for (int i = 0; i < 50 && !acc; i++) begin
         if (cmd_ready) acc = 1;
         tick();
      end
      cmd_valid = 1'b0;
      chk("accept", {31'd0, acc}, 32'd1);
      exp_count = exp_count + 8'd1;
   endtask

   task automatic wait_tx_req(input string tag);
      int i;
      i = 0;
      while (!tx_req && i < 50) begin
         tick();
         i++;
      end
      chk(tag, {31'd0, tx_req}, 32'd1);
   endtask

   // Issues one command, answers it d cycles after its last byte, and checks completion.
   task automatic run_cmd(input logic [7:0] code, input logic [15:0] arg, input int d);
      int         nb, base_hs, k, lat_exp;
      bit         rsp_exp, to_exp, done;
      logic [7:0] rbyte;
      nb      = model_push(code, arg);
      rsp_exp = (code == 8'h01) || (code == 8'h06);
      to_exp  = 0;
`ifdef BRIDGE_HOST_TIMEOUT_EN
      if (rsp_exp && d >= TO) to_exp = 1;
`endif
      rbyte   = 8'($urandom_range(0, 255));
      lat_exp = to_exp ? TO : d + 1;
      base_hs = tx_hs_count;
      accept_cmd(code, arg);
      k    = -1;
      done = 0;
      for (int i = 0; i < 3000 && !done; i++) begin
         if (cmd_done) begin
            done = 1;
         end else begin
            if (k < 0 && tx_hs_count == base_hs + nb) k = 0;
            if (rsp_exp && !to_exp && k == d) begin
               rx_data  = rbyte;
               rx_ready = 1'b1;
            end
            tick();
            rx_ready = 1'b0;
            if (k >= 0) k++;
         end
      end
      if (rsp_exp && !to_exp) exp_rsp_data = rbyte;
      chk("cmd_done_seen", {31'd0, done}, 32'd1);
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, rsp_exp && !to_exp});
      chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, to_exp});
      chk("rsp_data", {24'd0, rsp_data}, {24'd0, exp_rsp_data});
      chk("bytes_left", exp_q.size(), 32'd0);
      chk("cmd_count", {24'd0, cmd_count}, {24'd0, exp_count});
      chk("cmd_ready_after_done", {31'd0, cmd_ready}, 32'd1);
      if (rsp_exp) chk("rsp_latency", k, lat_exp);
      tick();
      chk("cmd_done_pulse", {31'd0, cmd_done}, 32'd0);
   endtask

   initial begin
      int         dn, d, r;
      logic [7:0] base, code;

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_code = '0; cmd_arg = '0;
      rx_data = '0; rx_ready = 1'b0; auto_en = 1;
      exp_count = '0; exp_rsp_data = '0;
      repeat (3) tick();
      chk("rst_tx_req", {31'd0, tx_req}, 32'd0);
      chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
      chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
      chk("rst_cmd_done", {31'd0, cmd_done}, 32'd0);
      chk("rst_cmd_count", {24'd0, cmd_count}, 32'd0);
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      tick();

      // NOP, BAUD, TEST with echo after 20 cycles
      run_cmd(8'h00, 16'h0000, 0);
      run_cmd(8'h04, 16'h01B1, 0);
      run_cmd(8'h01, 16'h005A, 20);
`ifdef BRIDGE_HOST_TIMEOUT_EN
      run_cmd(8'h06, 16'h0033, 100);
`else
      run_cmd(8'h06, 16'h0033, 40);
`endif

      // stray rx byte while idle
      rx_data  = 8'hC3;
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("stray_rsp_valid", {31'd0, rsp_valid}, 32'd0);
         chk("stray_rsp_data", {24'd0, rsp_data}, {24'd0, exp_rsp_data});
         tick();
      end

      // request held through a busy command
      base = exp_count;
      void'(model_push(8'h00, 16'h0000));
      void'(model_push(8'h00, 16'h0000));
      cmd_code = 8'h00; cmd_arg = 16'h0000; cmd_valid = 1'b1;
      dn = 0;
      for (int i = 0; i < 300 && dn < 2; i++) begin
         tick();
         if (cmd_done) begin
            dn++;
            chk("held_count_at_done", {24'd0, cmd_count}, {24'd0, 8'(base + 8'(dn))});
            if (dn == 2) cmd_valid = 1'b0;
         end else if (busy) begin
            chk("held_count_busy", {24'd0, cmd_count}, {24'd0, 8'(base + 8'(dn) + 8'd1)});
         end
      end
      cmd_valid = 1'b0;
      exp_count = base + 8'd2;
      chk("held_dones", dn, 32'd2);
      tick();
      chk("held_no_third", {24'd0, cmd_count}, {24'd0, exp_count});
      chk("held_bytes_left", exp_q.size(), 32'd0);

      // response arriving with the last tx accept
      auto_en = 0; tx_ready = 1'b0;
      void'(model_push(8'h01, 16'h0077));
      accept_cmd(8'h01, 16'h0077);
      wait_tx_req("same_op_req");
      tx_ready = 1'b1; tick(); tx_ready = 1'b0;
      wait_tx_req("same_arg_req");
      tx_ready = 1'b1; rx_ready = 1'b1; rx_data = 8'h9E;
      tick();
      tx_ready = 1'b0; rx_ready = 1'b0;
      exp_rsp_data = 8'h9E;
      chk("same_cmd_done", {31'd0, cmd_done}, 32'd1);
      chk("same_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("same_rsp_data", {24'd0, rsp_data}, 32'h9E);
      chk("same_bytes_left", exp_q.size(), 32'd0);
      tick();

      // reset during the BAUD low-byte send
      void'(model_push(8'h04, 16'h01B1));
      accept_cmd(8'h04, 16'h01B1);
      wait_tx_req("rst_op_req");
      tx_ready = 1'b1; tick(); tx_ready = 1'b0;
      wait_tx_req("rst_arg_req");
      rst_n = 1'b0;
      tick();
      chk("midrst_tx_req", {31'd0, tx_req}, 32'd0);
      chk("midrst_cmd_count", {24'd0, cmd_count}, 32'd0);
      chk("midrst_cmd_done", {31'd0, cmd_done}, 32'd0);
      chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      rst_n = 1'b1;
      exp_q.delete();
      exp_count = '0;
      exp_rsp_data = '0;
      auto_en = 1;
      tick();
      chk("midrst_no_done", {31'd0, cmd_done}, 32'd0);
      run_cmd(8'h00, 16'h0000, 0);

      // randomized stream, long enough for cmd_count to wrap
      for (int n = 0; n < 270; n++) begin
         r = $urandom_range(0, 9);
         if (r <= 6) code = 8'(r);
         else code = 8'($urandom_range(7, 255));
         d = $urandom_range(0, 8);
`ifdef BRIDGE_HOST_TIMEOUT_EN
         if ($urandom_range(0, 7) == 0) d = TO + 4;
`endif
         run_cmd(code, 16'($urandom_range(0, 65535)), d);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bridge_host_fsm.md
Name: bridge_host_fsm

Overview:
- Host-side command initiator for the UART-to-SPI bridge command protocol. It is the issuing end of that byte stream.
- Accepts one command per request on a parallel interface, serializes it as opcode plus argument bytes into a UART transmitter, then collects the single response byte for TEST/TRANSFER.
- Used for board-to-board bridging and as the stimulus engine in system benches.

Parameters:
- TIMEOUT_CYCLES, 24'd1000000, cycles to wait for a response byte before abandoning; valid range 2..2^24-1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- cmd_valid  input  1  command request
- cmd_ready  output  1  high only in S_IDLE; command accepted when cmd_valid && cmd_ready
- cmd_code  input  8  opcode: 00 NOP, 01 TEST, 02 SPI_CLK, 03 SPI_MODE, 04 BAUD, 05 CHIPSEL, 06 TRANSFER
- cmd_arg  input  16  argument; [7:0] is the 1-byte arg or BAUD low byte; [15:8] is the BAUD high byte
- cmd_done  output  1  one-cycle pulse when a command completes (including timeout)
- rsp_valid  output  1  one-cycle pulse, rsp_data valid
- rsp_data  output  8  response byte, held until the next response
- rsp_timeout  output  1  one-cycle pulse coincident with cmd_done on timeout
- busy  output  1  ~cmd_ready
- tx_req  output  1  UART transmit request, held until tx_ready
- tx_data  output  8  byte to transmit
- tx_ready  input  1  UART accepted the byte
- rx_data  input  8  received byte
- rx_ready  input  1  one-cycle pulse, rx_data valid
- cmd_count  output  8  commands accepted, wraps FF->00

Behaviour:
- Reset (rst_n low at a clock edge): tx_req=0, tx_data=00, rsp_data=00, cmd_done=rsp_valid=rsp_timeout=0, cmd_count=00, state=S_IDLE.
- Reset mid-command abandons the command with no cmd_done; tx_req drops at that edge.
- Acceptance: cmd_code and cmd_arg are latched; cmd_count increments; next state is S_OP.
- Argument byte count:
  - NOP: 0.
  - BAUD: 2 (low byte first).
  - All other opcodes 01..06: 1.
  - Unknown codes: 0 (opcode byte sent only, no response expected).
- Response expected only for TEST (01) and TRANSFER (06).
- Byte send phase (S_OP, S_ARG_L, S_ARG_H):
  - Cycle after entry: tx_data is loaded and tx_req=1.
  - On a cycle with tx_ready sampled high: tx_req is cleared at that edge and the state advances.
  - tx_req is low for at least 1 cycle between consecutive bytes.
  - tx_data is stable while tx_req=1.
- Transitions:
  - S_IDLE -> S_OP.
  - S_OP -> S_ARG_L (arg count >= 1), else DONE.
  - S_ARG_L -> S_ARG_H (BAUD), or S_RSP (response expected), else DONE.
  - S_ARG_H -> DONE.
  - S_RSP -> DONE on rx_ready (rsp_data <= rx_data, rsp_valid=1) or on timeout.
- DONE means: cmd_done pulses at the transition edge and the next state is S_IDLE. Minimum turnaround is 1 idle cycle (cmd_ready high) before the next acceptance.
- rx_ready arriving in S_ARG_L of a response command in the same cycle as tx_ready is captured as the response; the FSM goes directly to DONE with rsp_valid.
- Any other rx_ready outside S_RSP is ignored.
- Timeout: 24-bit counter, cleared on entry to S_RSP, increments each S_RSP cycle without rx_ready. At count == TIMEOUT_CYCLES-1: rsp_timeout and cmd_done pulse, rsp_data unchanged, return to S_IDLE.
- rx_ready on the exact timeout cycle wins: response, no timeout.
- cmd_valid while busy is ignored; no queuing.

Optional Feature:
- Macro: BRIDGE_HOST_TIMEOUT_EN.
- Defined: timeout counter and rsp_timeout behave as above.
- Undefined: no counter is built; S_RSP waits indefinitely for rx_ready; rsp_timeout is tied to 0; TIMEOUT_CYCLES is unused.

Test Plan:
- Reset then NOP (cmd_code=00): exactly one tx byte 00; cmd_done pulses after tx_ready; cmd_count=01; no rsp_valid.
- BAUD, cmd_arg=16'h01B1: tx bytes 04, B1, 01 in order; tx_req low >= 1 cycle between bytes; cmd_done after the third tx_ready.
- TEST, arg=5A, bench echoes rx_data=5A 20 cycles after the last byte: tx bytes 01, 5A; rsp_valid pulse with rsp_data=5A, coincident with cmd_done.
- TRANSFER with TIMEOUT_CYCLES=16 and no reply (macro defined): tx bytes 06, arg; rsp_timeout and cmd_done pulse exactly 16 cycles after entering S_RSP; cmd_ready returns high.
- Stray rx_ready=C3 while idle, then cmd_valid held during busy: stray byte ignored (rsp_valid stays 0); second request accepted only after cmd_done; cmd_count increments once per acceptance.
- rst_n low during the S_ARG_L of BAUD: tx_req=0 and cmd_count=00 after the edge; no cmd_done; a fresh NOP issued after reset completes normally.
